// File: rtl/display_ctrl.sv
// Seven-segment and LED display controller on the J1 I/O bus.
// Holds the register file, blink prescaler and LED brightness PWM, and drives registered board pins.
module display_ctrl #(
    parameter int          N_HEX     = 4,
    parameter int          N_LEDG    = 8,
    parameter int          N_LEDR    = 10,
    parameter logic [15:0] BASE      = 16'h0040,
    parameter int          BLINK_DIV = 25_000_000
) (
    input  logic               clk,
    input  logic               reset,
    output logic [N_HEX*7-1:0] hex,
    output logic [N_LEDG-1:0]  ledg,
    output logic [N_LEDR-1:0]  ledr,
    input  logic [15:0]        io_addr,
    input  logic [15:0]        io_dout,
    output logic [15:0]        io_din,
    input  logic               io_wr,
    input  logic               io_rd
);

    localparam int PW = $clog2(BLINK_DIV);
    localparam logic [PW-1:0] PS_LAST = PW'(BLINK_DIV - 1);

    logic [N_LEDG-1:0]  ledg_r;
    logic [N_LEDR-1:0]  ledr_r;
    logic [N_HEX-1:0]   mode_r;
    logic [N_HEX-1:0]   blink_r;
    logic [3:0]         bright_r;
    logic [6:0]         digit_r [N_HEX];

    logic [15:0]        off;
    logic [15:0]        rdata;
    logic [PW-1:0]      ps_cnt;
    logic               phase;
    logic [3:0]         pwm_cnt;
    logic               led_on;
    logic [N_HEX*7-1:0] hex_next;

    function automatic logic [6:0] seg_decode(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'h3F;
            4'h1: s = 7'h06;
            4'h2: s = 7'h5B;
            4'h3: s = 7'h4F;
            4'h4: s = 7'h66;
            4'h5: s = 7'h6D;
            4'h6: s = 7'h7D;
            4'h7: s = 7'h07;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h6F;
            4'hA: s = 7'h77;
            4'hB: s = 7'h7C;
            4'hC: s = 7'h39;
            4'hD: s = 7'h5E;
            4'hE: s = 7'h79;
            default: s = 7'h71;
        endcase
        return s;
    endfunction

    // Offset wraps modulo 2^16, so addresses below BASE land far outside the map.
    always_comb begin
        off = io_addr - BASE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ledg_r   <= '0;
            ledr_r   <= '0;
            mode_r   <= '0;
            blink_r  <= '0;
            bright_r <= 4'hF;
            for (int unsigned i = 0; i < N_HEX; i++) begin
                digit_r[i] <= '0;
            end
        end else if (io_wr) begin
            case (off)
                16'd0:   ledg_r   <= io_dout[N_LEDG-1:0];
                16'd1:   ledr_r   <= io_dout[N_LEDR-1:0];
                16'd2:   mode_r   <= io_dout[N_HEX-1:0];
                16'd3:   blink_r  <= io_dout[N_HEX-1:0];
                16'd4:   bright_r <= io_dout[3:0];
                default: ;
            endcase
            for (int unsigned i = 0; i < N_HEX; i++) begin
                if (off == 16'(8 + i)) begin
                    digit_r[i] <= io_dout[6:0];
                end
            end
        end
    end

    always_comb begin
        rdata = '0;
        case (off)
            16'd0:   rdata[N_LEDG-1:0] = ledg_r;
            16'd1:   rdata[N_LEDR-1:0] = ledr_r;
            16'd2:   rdata[N_HEX-1:0]  = mode_r;
            16'd3:   rdata[N_HEX-1:0]  = blink_r;
            16'd4:   rdata[3:0]        = bright_r;
            default: ;
        endcase
        for (int unsigned i = 0; i < N_HEX; i++) begin
            if (off == 16'(8 + i)) begin
                rdata[6:0] = digit_r[i];
            end
        end
    end

    // Read data is sampled from pre-write register state, giving read-before-write on collisions.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            io_din <= '0;
        end else if (io_rd) begin
            io_din <= rdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ps_cnt  <= '0;
            phase   <= 1'b0;
            pwm_cnt <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + 4'd1;
            if (ps_cnt == PS_LAST) begin
                ps_cnt <= '0;
                phase  <= ~phase;
            end else begin
                ps_cnt <= ps_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        led_on   = (bright_r == 4'hF) || (pwm_cnt < bright_r);
        hex_next = '1;
        for (int unsigned i = 0; i < N_HEX; i++) begin
            if (blink_r[i] && phase) begin
                hex_next[i*7 +: 7] = 7'h7F;
            end else if (mode_r[i]) begin
                hex_next[i*7 +: 7] = ~seg_decode(digit_r[i][3:0]);
            end else begin
                hex_next[i*7 +: 7] = ~digit_r[i];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hex  <= '1;
            ledg <= '0;
            ledr <= '0;
        end else begin
            hex  <= hex_next;
            ledg <= led_on ? ledg_r : '0;
            ledr <= led_on ? ledr_r : '0;
        end
    end

endmodule

// File: tb/tb_display_ctrl.sv
// Randomized self-checking bench for display_ctrl against a cycle-count based reference model.
module tb_display_ctrl;

    localparam int          NH  = 4;
    localparam int          NLG = 8;
    localparam int          NLR = 10;
    localparam logic [15:0] BS  = 16'h0040;
    localparam int          BD  = 4;

    logic            clk = 1'b0;
    logic            reset;
    logic [NH*7-1:0] hex;
    logic [NLG-1:0]  ledg;
    logic [NLR-1:0]  ledr;
    logic [15:0]     io_addr;
    logic [15:0]     io_dout;
    logic [15:0]     io_din;
    logic            io_wr;
    logic            io_rd;

    int checks = 0;
    int errors = 0;
    int edges;

    logic [15:0] mreg [16];
    logic [6:0]  seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                  7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    display_ctrl #(.N_HEX(NH), .N_LEDG(NLG), .N_LEDR(NLR), .BASE(BS), .BLINK_DIV(BD)) dut (
        .clk(clk), .reset(reset), .hex(hex), .ledg(ledg), .ledr(ledr),
        .io_addr(io_addr), .io_dout(io_dout), .io_din(io_din), .io_wr(io_wr), .io_rd(io_rd)
    );

    always #5 clk = ~clk;

    // Rising edges since the last reset release; all model timing derives from this.
    always @(posedge clk or posedge reset) begin
        if (reset) edges <= 0;
        else       edges <= edges + 1;
    end

    function automatic logic [15:0] reg_mask(input int off);
        if (off == 0) return 16'((32'd1 << NLG) - 1);
        if (off == 1) return 16'((32'd1 << NLR) - 1);
        if (off == 2 || off == 3) return 16'((32'd1 << NH) - 1);
        if (off == 4) return 16'h000F;
        return 16'h007F;
    endfunction

    function automatic bit in_map(input logic [15:0] a);
        int off;
        off = int'(16'(a - BS));
        return (off <= 4) || (off >= 8 && off < 8 + NH);
    endfunction

    function automatic logic [15:0] model_read(input logic [15:0] a);
        if (!in_map(a)) return 16'h0000;
        return mreg[int'(16'(a - BS))];
    endfunction

    function automatic logic [6:0] exp_hex(input int i);
        logic [6:0] d;
        logic [6:0] pat;
        bit         dark;
        d    = mreg[8 + i][6:0];
        pat  = mreg[2][i] ? seg_tab[d[3:0]] : d;
        dark = mreg[3][i] && ((((edges - 1) / BD) % 2) == 1);
        return dark ? 7'h7F : ~pat;
    endfunction

    function automatic logic [15:0] exp_led(input logic [15:0] v);
        int br;
        br = int'(mreg[4][3:0]);
        if (br == 15 || ((edges - 1) % 16) < br) return v;
        return 16'h0000;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) mreg[i] = 16'h0000;
        mreg[4] = 16'h000F;
    endtask

    task automatic wr_addr(input logic [15:0] a, input logic [15:0] v);
        @(negedge clk);
        io_addr = a;
        io_dout = v;
        io_wr   = 1'b1;
        @(negedge clk);
        io_wr = 1'b0;
        if (in_map(a)) mreg[int'(16'(a - BS))] = v & reg_mask(int'(16'(a - BS)));
    endtask

    task automatic wr_off(input int off, input logic [15:0] v);
        wr_addr(BS + 16'(off), v);
    endtask

    task automatic rd_addr(input logic [15:0] a, output logic [15:0] d);
        @(negedge clk);
        io_addr = a;
        io_rd   = 1'b1;
        @(negedge clk);
        io_rd = 1'b0;
        d = io_din;
    endtask

    task automatic test_reset();
        logic [15:0] d;
        wr_off(0, 16'h00FF);
        wr_off(1, 16'h03FF);
        wr_off(2, 16'h000F);
        wr_off(8, 16'h0008);
        rd_addr(BS, d);
        checks++;
        if (d !== 16'h00FF) begin errors++; $display("FAIL pre_reset_read got %h exp %h", d, 16'h00FF); end
        @(negedge clk);
        checks++;
        if (ledg !== 8'hFF) begin errors++; $display("FAIL pre_reset_ledg got %h exp %h", ledg, 8'hFF); end
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        checks++;
        if (hex !== {NH*7{1'b1}}) begin errors++; $display("FAIL reset_hex got %h exp all ones", hex); end
        checks++;
        if (ledg !== '0 || ledr !== '0) begin errors++; $display("FAIL reset_leds got %h/%h exp 0/0", ledg, ledr); end
        checks++;
        if (io_din !== 16'h0000) begin errors++; $display("FAIL reset_din got %h exp 0000", io_din); end
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        rd_addr(BS + 16'd4, d);
        checks++;
        if (d !== 16'h000F) begin errors++; $display("FAIL reset_bright got %h exp 000F", d); end
        @(negedge clk);
        checks++;
        if (hex !== {NH*7{1'b1}}) begin errors++; $display("FAIL post_reset_hex got %h exp all ones", hex); end
    endtask

    task automatic test_decode();
        wr_off(2, 16'h0001);
        wr_off(8, 16'h000A);
        @(negedge clk);
        checks++;
        if (hex[6:0] !== 7'h08) begin errors++; $display("FAIL decode_A got %h exp 08", hex[6:0]); end
        wr_off(2, 16'h0000);
        @(negedge clk);
        checks++;
        if (hex[6:0] !== 7'h75) begin errors++; $display("FAIL raw_reinterp got %h exp 75", hex[6:0]); end
        wr_off(9, 16'h0049);
        @(negedge clk);
        checks++;
        if (hex[13:7] !== 7'h36) begin errors++; $display("FAIL raw_digit1 got %h exp 36", hex[13:7]); end
        for (int it = 0; it < 12; it++) begin
            wr_off(2, 16'($urandom));
            for (int i = 0; i < NH; i++) wr_off(8 + i, 16'($urandom));
            @(negedge clk);
            for (int i = 0; i < NH; i++) begin
                checks++;
                if (hex[i*7 +: 7] !== exp_hex(i)) begin
                    errors++;
                    $display("FAIL decode_rand digit %0d got %h exp %h", i, hex[i*7 +: 7], exp_hex(i));
                end
            end
        end
    endtask

    task automatic test_blink();
        int dark_cnt;
        int n;
        wr_off(2, 16'h0000);
        wr_off(8, 16'h007F);
        wr_off(3, 16'h0001);
        @(negedge clk);
        dark_cnt = 0;
        for (int c = 0; c < 24; c++) begin
            @(negedge clk);
            checks++;
            if (hex[6:0] !== exp_hex(0)) begin
                errors++;
                $display("FAIL blink_seq cycle %0d got %h exp %h", c, hex[6:0], exp_hex(0));
            end
            if (hex[6:0] === 7'h7F) dark_cnt++;
            else if (hex[6:0] !== 7'h00) dark_cnt = dark_cnt + 100;
        end
        checks++;
        if (dark_cnt !== 12) begin errors++; $display("FAIL blink_duty got %0d exp 12", dark_cnt); end
        n = 0;
        while (!(((((edges - 1) / BD) % 2) == 1) && ((((edges + 1) / BD) % 2) == 1)) && n < 32) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 32) begin errors++; $display("FAIL blink_wait got timeout exp dark window"); end
        checks++;
        if (hex[6:0] !== 7'h7F) begin errors++; $display("FAIL blink_dark got %h exp 7F", hex[6:0]); end
        io_addr = BS + 16'd3;
        io_dout = 16'h0000;
        io_wr   = 1'b1;
        @(negedge clk);
        io_wr   = 1'b0;
        mreg[3] = 16'h0000;
        @(negedge clk);
        checks++;
        if (hex[6:0] !== 7'h00) begin errors++; $display("FAIL blink_clear got %h exp 00", hex[6:0]); end
        for (int it = 0; it < 3; it++) begin
            wr_off(2, 16'($urandom));
            wr_off(3, 16'($urandom));
            for (int i = 0; i < NH; i++) wr_off(8 + i, 16'($urandom));
            for (int c = 0; c < 12; c++) begin
                @(negedge clk);
                for (int i = 0; i < NH; i++) begin
                    checks++;
                    if (hex[i*7 +: 7] !== exp_hex(i)) begin
                        errors++;
                        $display("FAIL blink_rand digit %0d got %h exp %h", i, hex[i*7 +: 7], exp_hex(i));
                    end
                end
            end
        end
        wr_off(3, 16'h0000);
    endtask

    task automatic test_pwm();
        int on_cnt;
        logic [15:0] e;
        wr_off(0, 16'h00FF);
        wr_off(1, 16'h0155);
        wr_off(4, 16'h0004);
        @(negedge clk);
        on_cnt = 0;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            e = exp_led(mreg[0]);
            checks++;
            if (ledg !== e[NLG-1:0]) begin errors++; $display("FAIL pwm4 cycle %0d got %h exp %h", c, ledg, e[NLG-1:0]); end
            if (ledg === 8'hFF) on_cnt++;
        end
        checks++;
        if (on_cnt !== 4) begin errors++; $display("FAIL pwm4_duty got %0d exp 4", on_cnt); end
        wr_off(4, 16'h0000);
        @(negedge clk);
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            checks++;
            if (ledg !== '0 || ledr !== '0) begin errors++; $display("FAIL pwm0 got %h/%h exp 0/0", ledg, ledr); end
        end
        wr_off(4, 16'h000F);
        @(negedge clk);
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            checks++;
            if (ledg !== 8'hFF || ledr !== 10'h155) begin
                errors++;
                $display("FAIL pwm15 got %h/%h exp FF/155", ledg, ledr);
            end
        end
        for (int it = 0; it < 6; it++) begin
            wr_off(0, 16'($urandom));
            wr_off(1, 16'($urandom));
            wr_off(4, 16'($urandom));
            for (int c = 0; c < 16; c++) begin
                @(negedge clk);
                e = exp_led(mreg[0]);
                checks++;
                if (ledg !== e[NLG-1:0]) begin errors++; $display("FAIL pwm_rand_g got %h exp %h", ledg, e[NLG-1:0]); end
                e = exp_led(mreg[1]);
                checks++;
                if (ledr !== e[NLR-1:0]) begin errors++; $display("FAIL pwm_rand_r got %h exp %h", ledr, e[NLR-1:0]); end
            end
        end
        wr_off(4, 16'h000F);
    endtask

    task automatic test_readback();
        logic [15:0] d;
        logic [15:0] a;
        wr_off(1, 16'hFFFF);
        rd_addr(BS + 16'd1, d);
        checks++;
        if (d !== 16'h03FF) begin errors++; $display("FAIL ledr_read got %h exp 03FF", d); end
        repeat (3) @(negedge clk);
        checks++;
        if (io_din !== 16'h03FF) begin errors++; $display("FAIL din_hold got %h exp 03FF", io_din); end
        rd_addr(BS + 16'd5, d);
        checks++;
        if (d !== 16'h0000) begin errors++; $display("FAIL read_off5 got %h exp 0000", d); end
        rd_addr(BS - 16'd1, d);
        checks++;
        if (d !== 16'h0000) begin errors++; $display("FAIL read_below_base got %h exp 0000", d); end
        wr_off(8 + NH, 16'h007F);
        @(negedge clk);
        for (int i = 0; i < NH; i++) begin
            checks++;
            if (hex[i*7 +: 7] !== exp_hex(i)) begin
                errors++;
                $display("FAIL write_oob digit %0d got %h exp %h", i, hex[i*7 +: 7], exp_hex(i));
            end
        end
        rd_addr(BS + 16'(8 + NH), d);
        checks++;
        if (d !== 16'h0000) begin errors++; $display("FAIL read_oob got %h exp 0000", d); end
        for (int it = 0; it < 24; it++) begin
            a = BS + 16'($urandom_range(0, 13));
            if (a == BS + 16'd3) a = BS + 16'd5;
            wr_addr(a, 16'($urandom));
            rd_addr(a, d);
            checks++;
            if (d !== model_read(a)) begin
                errors++;
                $display("FAIL readback off %0d got %h exp %h", int'(16'(a - BS)), d, model_read(a));
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] d;
        wr_off(0, 16'h0012);
        @(negedge clk);
        io_addr = BS;
        io_dout = 16'h0034;
        io_wr   = 1'b1;
        io_rd   = 1'b1;
        @(negedge clk);
        io_wr   = 1'b0;
        io_rd   = 1'b0;
        mreg[0] = 16'h0034;
        checks++;
        if (io_din !== 16'h0012) begin errors++; $display("FAIL wr_rd_same got %h exp 0012", io_din); end
        rd_addr(BS, d);
        checks++;
        if (d !== 16'h0034) begin errors++; $display("FAIL wr_rd_after got %h exp 0034", d); end
    endtask

    initial begin
        reset   = 1'b1;
        io_addr = '0;
        io_dout = '0;
        io_wr   = 1'b0;
        io_rd   = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        test_reset();
        test_decode();
        test_blink();
        test_pwm();
        test_readback();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
